// File: rtl/uart_pkg.sv
// Shared constants and state types for the memory-mapped 8N1 UART peripheral.
package uart_pkg;

   localparam logic [31:0] UART_TXD = 32'h4000_0018;
   localparam logic [31:0] UART_RXD = 32'h4000_001C;
   localparam logic [31:0] UART_CON = 32'h4000_0020;

   localparam int CON_TX_IE     = 0;
   localparam int CON_RX_IE     = 1;
   localparam int CON_RX_READY  = 2;
   localparam int CON_TX_DONE   = 3;
   localparam int CON_TX_BUSY   = 4;
   localparam int CON_OVERRUN   = 5;
   localparam int CON_FRAME_ERR = 6;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/uart_rx_fsm.sv
// Serial receiver: 2-flop synchroniser, mid-bit sampling FSM and LSB-first shift register.
module uart_rx_fsm
   import uart_pkg::*;
#(
   parameter int DIV = 16
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_byte,
   output logic       rx_done,
   output logic       rx_ferr
);

   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] HALF = CNT_W'((DIV / 2 > 0) ? DIV / 2 - 1 : 0);

   logic             rx_p0, rx_p1, rx_p2;
   rx_state_t        state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bits;
   logic [7:0]       shift;

   assign rx_byte = shift;

   // Stage p0/p1: metastability guard; p2 holds the previous synchronised level for edge detect
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_p0 <= 1'b1;
         rx_p1 <= 1'b1;
         rx_p2 <= 1'b1;
      end else begin
         rx_p0 <= rx;
         rx_p1 <= rx_p0;
         rx_p2 <= rx_p1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= RX_IDLE;
         cnt     <= '0;
         bits    <= '0;
         shift   <= '0;
         rx_done <= 1'b0;
         rx_ferr <= 1'b0;
      end else begin
         rx_done <= 1'b0;
         rx_ferr <= 1'b0;
         case (state)
            RX_IDLE: begin
               if (rx_p2 && !rx_p1) begin
                  state <= RX_START;
                  cnt   <= '0;
                  bits  <= '0;
               end
            end
            RX_START: begin
               if (cnt == HALF) begin
                  // a start bit that is gone by mid-bit was a glitch
                  state <= rx_p1 ? RX_IDLE : RX_DATA;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RX_DATA: begin
               if (cnt == LAST) begin
                  shift <= {rx_p1, shift[7:1]};
                  cnt   <= '0;
                  if (bits == 3'd7) state <= RX_STOP;
                  else              bits  <= bits + 3'd1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RX_STOP: begin
               if (cnt == LAST) begin
                  rx_done <= rx_p1;
                  rx_ferr <= !rx_p1;
                  state   <= RX_IDLE;
                  cnt     <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_periph.sv
// Memory-mapped UART: TXD/RXD/CON register decode, TX serialiser, status flags and irq.
module uart_periph
   import uart_pkg::*;
#(
   parameter int          CLK_FREQ = 50000000,
   parameter int          BAUD     = 9600,
   parameter logic [31:0] BASE     = UART_TXD
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        MemWrite,
   input  logic        MemRead,
   output logic [31:0] rdata,
   input  logic        rx,
   output logic        tx,
   output logic        irq
);

   localparam int DIV   = CLK_FREQ / BAUD;
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);
   localparam logic [31:0] TXD_ADDR = BASE;
   localparam logic [31:0] RXD_ADDR = BASE + (UART_RXD - UART_TXD);
   localparam logic [31:0] CON_ADDR = BASE + (UART_CON - UART_TXD);

   tx_state_t        tx_state;
   logic [CNT_W-1:0] tx_cnt;
   logic [2:0]       tx_bit;
   logic [7:0]       tx_shift;
   logic             tx_busy, tx_finish;

   logic       tx_ie, rx_ie, tx_done, rx_ready, overrun, frame_err;
   logic [7:0] rx_data, rx_byte;
   logic       rx_done, rx_ferr;
   logic       hit_txd, hit_rxd, hit_con;
   logic       txd_wr, con_wr, con_rd, rxd_rd;
   logic [31:0] con_word;
   logic       wdata_unused;

   assign wdata_unused = ^wdata[31:8];

   assign hit_txd = (addr == TXD_ADDR);
   assign hit_rxd = (addr == RXD_ADDR);
   assign hit_con = (addr == CON_ADDR);

   assign tx_busy   = (tx_state != TX_IDLE);
   assign tx_finish = (tx_state == TX_STOP) && (tx_cnt == LAST);
   assign txd_wr    = MemWrite && hit_txd && !tx_busy;
   assign con_wr    = MemWrite && hit_con;
   assign con_rd    = MemRead && hit_con;
   assign rxd_rd    = MemRead && hit_rxd;

   always_comb begin
      con_word                = '0;
      con_word[CON_TX_IE]     = tx_ie;
      con_word[CON_RX_IE]     = rx_ie;
      con_word[CON_RX_READY]  = rx_ready;
      con_word[CON_TX_DONE]   = tx_done;
      con_word[CON_TX_BUSY]   = tx_busy;
      con_word[CON_OVERRUN]   = overrun;
      con_word[CON_FRAME_ERR] = frame_err;
   end

   always_comb begin
      rdata = '0;
      if (MemRead) begin
         if (hit_rxd)      rdata = {24'b0, rx_data};
         else if (hit_con) rdata = con_word;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         tx       <= 1'b1;
      end else begin
         case (tx_state)
            TX_IDLE: begin
               if (txd_wr) begin
                  tx_shift <= wdata[7:0];
                  tx_state <= TX_START;
                  tx_cnt   <= '0;
                  tx       <= 1'b0;
               end
            end
            TX_START: begin
               if (tx_cnt == LAST) begin
                  tx_state <= TX_DATA;
                  tx_cnt   <= '0;
                  tx_bit   <= '0;
                  tx       <= tx_shift[0];
               end else begin
                  tx_cnt <= tx_cnt + CNT_W'(1);
               end
            end
            TX_DATA: begin
               if (tx_cnt == LAST) begin
                  tx_cnt <= '0;
                  if (tx_bit == 3'd7) begin
                     tx_state <= TX_STOP;
                     tx       <= 1'b1;
                  end else begin
                     tx_bit   <= tx_bit + 3'd1;
                     tx_shift <= {1'b0, tx_shift[7:1]};
                     tx       <= tx_shift[1];
                  end
               end else begin
                  tx_cnt <= tx_cnt + CNT_W'(1);
               end
            end
            TX_STOP: begin
               if (tx_cnt == LAST) begin
                  tx_state <= TX_IDLE;
                  tx_cnt   <= '0;
               end else begin
                  tx_cnt <= tx_cnt + CNT_W'(1);
               end
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   // Later assignments win, so flag sets override read-clears on the same edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_ie     <= 1'b0;
         rx_ie     <= 1'b0;
         tx_done   <= 1'b0;
         rx_ready  <= 1'b0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
         rx_data   <= '0;
         irq       <= 1'b0;
      end else begin
         if (con_wr) begin
            tx_ie <= wdata[CON_TX_IE];
            rx_ie <= wdata[CON_RX_IE];
         end
         if (con_rd) begin
            rx_ready  <= 1'b0;
            tx_done   <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
         end
         if (rxd_rd)    rx_ready <= 1'b0;
         if (txd_wr)    tx_done  <= 1'b0;
         if (tx_finish) tx_done  <= 1'b1;
         if (rx_done) begin
            rx_data  <= rx_byte;
            rx_ready <= 1'b1;
            if (rx_ready) overrun <= 1'b1;
         end
         if (rx_ferr) frame_err <= 1'b1;
         irq <= (tx_ie & tx_done) | (rx_ie & rx_ready);
      end
   end

   uart_rx_fsm #(.DIV(DIV)) u_rx (
      .clk     (clk),
      .rst     (rst),
      .rx      (rx),
      .rx_byte (rx_byte),
      .rx_done (rx_done),
      .rx_ferr (rx_ferr)
   );

endmodule

// File: tb/tb_uart_periph.sv
// Self-checking bench for uart_periph at DIV=16 against a flag-level reference model.
module tb_uart_periph;

   localparam int DIV = 16;
   localparam logic [31:0] A_TXD = 32'h4000_0018;
   localparam logic [31:0] A_RXD = 32'h4000_001C;
   localparam logic [31:0] A_CON = 32'h4000_0020;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        MemWrite = 1'b0;
   logic        MemRead = 1'b0;
   logic [31:0] rdata;
   logic        rx_drv = 1'b1;
   logic        loop_en = 1'b0;
   logic        rx_line;
   logic        tx;
   logic        irq;

   int checks = 0;
   int errors = 0;

   bit       m_tx_ie, m_rx_ie, m_tx_done, m_rx_ready, m_overrun, m_ferr;
   logic [7:0] m_rx_data = 8'h00;

   assign rx_line = loop_en ? tx : rx_drv;

   uart_periph #(.CLK_FREQ(16), .BAUD(1), .BASE(A_TXD)) dut (
      .clk      (clk),
      .rst      (rst),
      .addr     (addr),
      .wdata    (wdata),
      .MemWrite (MemWrite),
      .MemRead  (MemRead),
      .rdata    (rdata),
      .rx       (rx_line),
      .tx       (tx),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] exp_con(input bit busy);
      return {25'b0, m_ferr, m_overrun, busy, m_tx_done, m_rx_ready, m_rx_ie, m_tx_ie};
   endfunction

   function automatic logic exp_irq();
      return (m_tx_ie & m_tx_done) | (m_rx_ie & m_rx_ready);
   endfunction

   task automatic model_con_read();
      m_rx_ready = 0; m_tx_done = 0; m_overrun = 0; m_ferr = 0;
   endtask

   task automatic model_rx_frame(input logic [7:0] b, input bit stop);
      if (stop) begin
         if (m_rx_ready) m_overrun = 1;
         m_rx_data  = b;
         m_rx_ready = 1;
      end else begin
         m_ferr = 1;
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      addr = a; wdata = d; MemWrite = 1'b1;
      @(posedge clk); #1;
      MemWrite = 1'b0; addr = '0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      addr = a; MemRead = 1'b1;
      #1 d = rdata;
      @(posedge clk); #1;
      MemRead = 1'b0; addr = '0;
   endtask

   task automatic drive_frame(input logic [7:0] b, input logic stop);
      rx_drv = 1'b0;
      cyc(DIV);
      for (int i = 0; i < 8; i++) begin
         rx_drv = b[i];
         cyc(DIV);
      end
      rx_drv = stop;
      cyc(DIV);
      rx_drv = 1'b1;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
      rst = 1'b0;
      cyc(2);
      bus_read(A_CON, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_con: got %h want 00000000", d); end
      bus_read(A_RXD, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_rxd: got %h want 00000000", d); end
      checks++; if (tx !== 1'b1 || irq !== 1'b0) begin errors++; $display("FAIL idle_lines: tx=%b irq=%b want 1/0", tx, irq); end
   endtask

   task automatic test_tx(input logic [7:0] b, input bit ie);
      logic [9:0]  frame;
      logic [31:0] d, exp;
      int wave_bad = 0, busy_bad = 0, first_k = -1;
      m_tx_ie = ie;
      bus_write(A_CON, {30'b0, m_rx_ie, m_tx_ie});
      frame = {1'b1, b, 1'b0};
      bus_write(A_TXD, {24'h0, b});
      m_tx_done = 0;
      for (int k = 0; k < 10 * DIV; k++) begin
         if (tx !== frame[k / DIV]) begin
            if (wave_bad == 0) first_k = k;
            wave_bad++;
         end
         if (k == 40) begin
            addr = A_TXD; wdata = {24'h0, ~b}; MemWrite = 1'b1;
         end else begin
            addr = A_CON; MemRead = 1'b1;
            #1;
            exp = exp_con(1'b1);
            if (rdata !== exp) busy_bad++;
            model_con_read();
         end
         @(posedge clk); #1;
         MemWrite = 1'b0; MemRead = 1'b0; addr = '0;
      end
      m_tx_done = 1;
      checks++; if (wave_bad != 0) begin errors++; $display("FAIL tx_wave %h: %0d bad cycles, first at cycle %0d, want 0", b, wave_bad, first_k); end
      checks++; if (busy_bad != 0) begin errors++; $display("FAIL tx_busy_con %h: %0d bad reads, want 0", b, busy_bad); end
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL tx_idle_after %h: got %b want 1", b, tx); end
      cyc(1);
      checks++; if (irq !== exp_irq()) begin errors++; $display("FAIL tx_irq %h: got %b want %b", b, irq, exp_irq()); end
      bus_read(A_CON, d);
      exp = exp_con(1'b0);
      checks++; if (d !== exp) begin errors++; $display("FAIL tx_done_con %h: got %h want %h", b, d, exp); end
      model_con_read();
      cyc(1);
      checks++; if (irq !== exp_irq()) begin errors++; $display("FAIL tx_irq_clear %h: got %b want %b", b, irq, exp_irq()); end
   endtask

   task automatic test_rx(input logic [7:0] b, input bit ie, input bit via_con);
      logic [31:0] d, exp;
      m_rx_ie = ie;
      bus_write(A_CON, {30'b0, m_rx_ie, m_tx_ie});
      drive_frame(b, 1'b1);
      model_rx_frame(b, 1'b1);
      cyc(2);
      checks++; if (irq !== exp_irq()) begin errors++; $display("FAIL rx_irq %h: got %b want %b", b, irq, exp_irq()); end
      if (via_con) begin
         bus_read(A_CON, d);
         exp = exp_con(1'b0);
         checks++; if (d !== exp) begin errors++; $display("FAIL rx_ready_con %h: got %h want %h", b, d, exp); end
         model_con_read();
      end
      bus_read(A_RXD, d);
      checks++; if (d !== {24'h0, m_rx_data}) begin errors++; $display("FAIL rx_data %h: got %h want %h", b, d, {24'h0, m_rx_data}); end
      m_rx_ready = 0;
      cyc(1);
      checks++; if (irq !== exp_irq()) begin errors++; $display("FAIL rx_irq_drop %h: got %b want %b", b, irq, exp_irq()); end
      bus_read(A_CON, d);
      exp = exp_con(1'b0);
      checks++; if (d !== exp) begin errors++; $display("FAIL rx_after_read_con %h: got %h want %h", b, d, exp); end
      model_con_read();
   endtask

   task automatic test_glitch();
      logic [31:0] d, exp;
      rx_drv = 1'b0;
      cyc(4);
      rx_drv = 1'b1;
      cyc(12 * DIV);
      bus_read(A_CON, d);
      exp = exp_con(1'b0);
      checks++; if (d !== exp) begin errors++; $display("FAIL glitch_con: got %h want %h", d, exp); end
      model_con_read();
      bus_read(A_RXD, d);
      checks++; if (d !== {24'h0, m_rx_data}) begin errors++; $display("FAIL glitch_rxd: got %h want %h", d, {24'h0, m_rx_data}); end
   endtask

   task automatic test_frame_err(input logic [7:0] b);
      logic [31:0] d, exp;
      drive_frame(b, 1'b0);
      model_rx_frame(b, 1'b0);
      cyc(4);
      bus_read(A_CON, d);
      exp = exp_con(1'b0);
      checks++; if (d !== exp) begin errors++; $display("FAIL ferr_con %h: got %h want %h", b, d, exp); end
      model_con_read();
      bus_read(A_RXD, d);
      checks++; if (d !== {24'h0, m_rx_data}) begin errors++; $display("FAIL ferr_rxd %h: got %h want %h", b, d, {24'h0, m_rx_data}); end
      bus_read(A_CON, d);
      exp = exp_con(1'b0);
      checks++; if (d !== exp) begin errors++; $display("FAIL ferr_cleared %h: got %h want %h", b, d, exp); end
   endtask

   task automatic test_overrun(input logic [7:0] b1, input logic [7:0] b2);
      logic [31:0] d, exp;
      drive_frame(b1, 1'b1);
      model_rx_frame(b1, 1'b1);
      drive_frame(b2, 1'b1);
      model_rx_frame(b2, 1'b1);
      cyc(2);
      bus_read(A_CON, d);
      exp = exp_con(1'b0);
      checks++; if (d !== exp) begin errors++; $display("FAIL ovr_con %h/%h: got %h want %h", b1, b2, d, exp); end
      model_con_read();
      bus_read(A_CON, d);
      exp = exp_con(1'b0);
      checks++; if (d !== exp) begin errors++; $display("FAIL ovr_cleared %h/%h: got %h want %h", b1, b2, d, exp); end
      bus_read(A_RXD, d);
      checks++; if (d !== {24'h0, m_rx_data}) begin errors++; $display("FAIL ovr_rxd %h/%h: got %h want %h", b1, b2, d, {24'h0, m_rx_data}); end
   endtask

   task automatic test_loopback(input logic [7:0] b);
      logic [31:0] d, exp;
      loop_en = 1'b1;
      m_tx_ie = 1; m_rx_ie = 1;
      bus_write(A_CON, 32'h3);
      bus_write(A_TXD, {24'h0, b});
      m_tx_done = 0;
      cyc(11 * DIV);
      model_rx_frame(b, 1'b1);
      m_tx_done = 1;
      checks++; if (irq !== exp_irq()) begin errors++; $display("FAIL loop_irq %h: got %b want %b", b, irq, exp_irq()); end
      bus_read(A_CON, d);
      exp = exp_con(1'b0);
      checks++; if (d !== exp) begin errors++; $display("FAIL loop_con %h: got %h want %h", b, d, exp); end
      model_con_read();
      bus_read(A_RXD, d);
      checks++; if (d !== {24'h0, b}) begin errors++; $display("FAIL loop_rxd %h: got %h want %h", b, d, {24'h0, b}); end
      loop_en = 1'b0;
   endtask

   task automatic test_async_reset();
      logic [31:0] d;
      m_tx_ie = 1; m_rx_ie = 1;
      bus_write(A_CON, 32'h3);
      bus_write(A_TXD, {24'h0, 8'($urandom)});
      cyc(5);
      checks++; if (tx !== 1'b0) begin errors++; $display("FAIL areset_pre_tx: got %b want 0", tx); end
      #2 rst = 1'b1;
      #1;
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL areset_tx: got %b want 1", tx); end
      m_tx_ie = 0; m_rx_ie = 0; m_tx_done = 0; m_rx_ready = 0; m_overrun = 0; m_ferr = 0; m_rx_data = 8'h00;
      cyc(2);
      rst = 1'b0;
      cyc(1);
      bus_read(A_CON, d);
      checks++; if (d !== exp_con(1'b0)) begin errors++; $display("FAIL areset_con: got %h want %h", d, exp_con(1'b0)); end
      bus_read(A_RXD, d);
      checks++; if (d !== {24'h0, m_rx_data}) begin errors++; $display("FAIL areset_rxd: got %h want %h", d, {24'h0, m_rx_data}); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL areset_irq: got %b want 0", irq); end
   endtask

   initial begin
      m_tx_ie = 0; m_rx_ie = 0; m_tx_done = 0; m_rx_ready = 0; m_overrun = 0; m_ferr = 0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_tx(8'hA5, 1'b0);
      test_tx(8'($urandom), 1'b1);
      test_rx(8'h3C, 1'b1, 1'b0);
      test_rx(8'($urandom), 1'b1, 1'b1);
      test_rx(8'($urandom), 1'b0, 1'b1);
      test_glitch();
      test_frame_err(8'($urandom));
      test_overrun(8'h11, 8'h22);
      test_overrun(8'($urandom), 8'($urandom));
      test_loopback(8'h5A);
      test_loopback(8'($urandom));
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_periph.md
Name: uart_periph

Overview:
Memory-mapped 8N1 UART peripheral on the CPU data bus, alongside data memory, LEDs, switches and digit tubes. It decodes the ALU-computed address for its three registers and serialises bytes onto tx. It deserialises bytes from rx and raises irq toward the Control block's interrupt input. It is the RX/TX/IRQ endpoint that the data-memory stage muxes into rdata.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 9600, line rate; DIV = CLK_FREQ/BAUD clocks per bit (integer division)
BASE, 32'h4000_0018, address of UART_TXD; UART_RXD = BASE+4, UART_CON = BASE+8

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
addr  input  32  byte address from ALU result
wdata  input  32  store data (register Rt)
MemWrite  input  1  store strobe, acts on the clk edge
MemRead  input  1  load strobe
rdata  output  32  read data, combinational; 0 when no register hit or MemRead=0
rx  input  1  serial in, asynchronous to clk
tx  output  1  serial out, idle high
irq  output  1  level interrupt request

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. On reset, all state machines go to IDLE, all registers and flags are cleared, tx=1, irq=0, and rx_data=0.
- Register map:
  - TXD (BASE), write-only: bits[7:0] form the byte to send.
  - RXD (BASE+4), read-only: {24'b0, rx_data}.
  - CON (BASE+8): bit0 tx_ie (RW), bit1 rx_ie (RW), bit2 rx_ready, bit3 tx_done, bit4 tx_busy, bit5 overrun, bit6 frame_err. Bits 2-6 are read-only; bits 7-31 read as 0.
- Reads:
  - Reading CON clears bits 2, 3, 5 and 6 on that clock edge.
  - Reading RXD clears rx_ready on that clock edge.
  - Clears act only on edges where MemRead=1 and the address matches.
- Write to TXD:
  - tx_busy=0: load the byte; the TX FSM goes to START on the next edge and clears tx_done.
  - tx_busy=1: the write is ignored, with no queueing.
- Write to CON updates only bits[1:0]. Writes to RXD or unmapped addresses are ignored.
- irq = (tx_ie & tx_done) | (rx_ie & rx_ready). It is registered, so it appears one cycle after the flag sets.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - START drives tx=0 for DIV cycles.
  - DATA sends 8 bits, LSB first, each held DIV cycles.
  - STOP drives tx=1 for DIV cycles, then sets tx_done and returns to IDLE.
  - tx_busy = (state != IDLE).
  - Total frame time is 10*DIV cycles from the first START cycle.
- RX input: rx passes through a 2-flop synchroniser before use.
- RX FSM: IDLE -> START -> DATA -> STOP.
  - IDLE: a falling edge on synchronised rx enters START with the bit counter at 0.
  - START: at DIV/2 cycles, if rx is still 0, go to DATA; otherwise it was a glitch, return to IDLE.
  - DATA: sample every DIV cycles (mid-bit), shift in LSB first, 8 samples.
  - STOP: after DIV cycles, sample rx.
    - Sample 1: rx_data <= shift register; set rx_ready. If rx_ready was already 1, set overrun and overwrite rx_data.
    - Sample 0: set frame_err, discard the byte, leave rx_data unchanged.
    - Either way, return to IDLE.
- Simultaneous events: a flag set wins over a read-clear in the same cycle.
- Independence: TX and RX run fully in parallel; a loopback (tx tied to rx) must work.
- Baud counters: free-reloading modulo DIV, restarted on every FSM state entry.

Decomposition:
- Shared package uart_pkg holds:
  - address constants UART_TXD, UART_RXD, UART_CON;
  - CON bit-index constants;
  - the TX and RX state enums (IDLE, START, DATA, STOP).
- One natural sub-module: uart_rx_fsm (synchroniser, RX FSM, shift register), instantiated once.
- The TX FSM and register decode stay in uart_periph.

Test Plan:
- Reset, then idle: tx=1, irq=0, and a CON read returns 0.
- TX frame (CLK_FREQ=16, BAUD=1, so DIV=16), write TXD=8'hA5:
  - tx=0 for 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then 1 for 16 cycles;
  - tx_busy=1 throughout;
  - tx_done=1 after 160 cycles;
  - a second write during busy is ignored.
- RX frame, drive 0x3C at DIV=16:
  - rx_ready sets after the stop bit;
  - RXD reads 32'h0000_003C;
  - with rx_ie=1, irq=1;
  - after the RXD read, rx_ready=0 and irq drops.
- Glitch and framing error:
  - an rx low pulse of 4 cycles produces no byte;
  - a frame with stop bit=0 sets frame_err=1, leaves rx_ready=0 and rx_data unchanged.
- Overrun: two bytes 0x11 then 0x22 without reading gives RXD=0x22 and overrun=1; a CON read returns bit5=1 and then clears it.
- Loopback: tx tied to rx, with tx_ie=rx_ie=1, write 0x5A, giving tx_done=1, rx_ready=1, RXD=0x5A and irq=1.
